// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master side supplies the operands and start; the slave side returns
// the busy/done status and the registered result.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor cell plus a borrow flop.
// A WIDTH-bit operation takes WIDTH RUN cycles, followed by a one-cycle
// DONE pulse. diff/borrow_out hold the last completed result.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);
    localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_sr_q, res_sr_d;
    logic             brw_q, brw_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bo_q, bo_d;

    logic             bit_x, bit_y, bit_d, brw_next;
    logic [WIDTH:0]   res_cat;
    logic [WIDTH-1:0] res_shift;

    // Full-subtractor cell on the current LSBs and the new result word.
    always_comb begin
        bit_x     = a_sr_q[0];
        bit_y     = b_sr_q[0];
        bit_d     = bit_x ^ bit_y ^ brw_q;
        brw_next  = (~bit_x & bit_y) | (~(bit_x ^ bit_y) & brw_q);
        res_cat   = {bit_d, res_sr_q};
        res_shift = res_cat[WIDTH:1];
    end

    // Next-state logic: operand load, per-bit shift and completion capture.
    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        brw_d    = brw_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        bo_d     = bo_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                // DONE accepts start too, so back-to-back operations lose no cycle.
                if (bus.start) begin
                    state_d = S_RUN;
                    a_sr_d  = bus.a;
                    b_sr_d  = bus.b;
                    brw_d   = 1'b0;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                res_sr_d = res_shift;
                brw_d    = brw_next;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    diff_d  = res_shift;
                    bo_d    = brw_next;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state and visible results; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bo_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bo_q    <= bo_d;
        end
    end

    // Operand and partial-result shift registers; always reloaded before use.
    always_ff @(posedge clk) begin
        a_sr_q   <= a_sr_d;
        b_sr_q   <= b_sr_d;
        res_sr_q <= res_sr_d;
    end

    assign bus.busy       = (state_q == S_RUN);
    assign bus.done       = (state_q == S_DONE);
    assign bus.diff       = diff_q;
    assign bus.borrow_out = bo_q;
endmodule
